vc_pop_arbiter: RTL and testbench

Round-robin pop scheduler sharing one downstream datapath among the four class FIFOs. Sits between the four input FIFOs and the output mux, reads their empty flags and the per-class `pause[3:0]` from the flow-control FSM, issues at most one one-hot pop per cycle, and registers the popped word with its source index. Supports bounded bursts per class, reports idle, and is held quiescent during `init`.

---
 rtl/vc_pop_arbiter_pkg.sv | 19 +
 rtl/vc_pop_arbiter_rr_pick4.sv | 27 ++
 rtl/vc_pop_arbiter.sv | 97 +++++++++
 tb/tb_vc_pop_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the class-FIFO pop scheduler and its round-robin search.
package vc_pop_arbiter_pkg;
    localparam int N_CLASS = 4;
    localparam int IDX_W   = 2;

    // One-hot encoding, matching the flow-control FSM.
    typedef enum logic [2:0] {
        ST_INIT = 3'b001,
        ST_IDLE = 3'b010,
        ST_ARB  = 3'b100
    } state_t;

    function automatic logic [N_CLASS-1:0] onehot(input logic [IDX_W-1:0] i);
        logic [N_CLASS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/vc_pop_arbiter_rr_pick4.sv
// Combinational round-robin search: first set bit of elig at or after start, wrapping mod 4.
module rr_pick4
    import vc_pop_arbiter_pkg::*;
(
    input  logic [N_CLASS-1:0] elig,
    input  logic [IDX_W-1:0]   start,
    output logic               found,
    output logic [IDX_W-1:0]   idx
);
    logic [2*N_CLASS-1:0] dbl_sh;
    logic [N_CLASS-1:0]   rot;

    // rot[k] is elig[(start + k) mod 4]
    assign dbl_sh = {elig, elig} >> start;
    assign rot    = dbl_sh[N_CLASS-1:0];

    always_comb begin
        found = 1'b0;
        idx   = start;
        for (int k = N_CLASS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                idx   = start + k[IDX_W-1:0];
            end
        end
    end
endmodule

// File: rtl/vc_pop_arbiter.sv
// Round-robin pop scheduler over four class FIFOs with bounded per-class bursts.
// Issues one one-hot pop per cycle and returns the popped word two cycles later.
module vc_pop_arbiter
    import vc_pop_arbiter_pkg::*;
#(
    parameter int DATA_W = 6,
    parameter int BURST  = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      init,
    input  logic [N_CLASS-1:0]        pause,
    input  logic [N_CLASS-1:0]        fifo_empty,
    input  logic [N_CLASS*DATA_W-1:0] fifo_data,
    output logic [N_CLASS-1:0]        pop,
    output logic [DATA_W-1:0]         data_out,
    output logic                      valid_out,
    output logic [IDX_W-1:0]          dest,
    output logic                      idle
);
    localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   start;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   grant_idx;
    logic [IDX_W-1:0]   sel_q;
    logic [CNT_W-1:0]   burst_cnt;
    logic [N_CLASS-1:0] elig;
    logic               found;
    logic               burst_ok;
    logic               grant;
    logic               v1;

    assign elig  = ~fifo_empty & ~pause;
    assign start = last + 2'd1;

    rr_pick4 u_pick (
        .elig  (elig),
        .start (start),
        .found (found),
        .idx   (pick_idx)
    );

    // Stay on the current class only while it is eligible and its burst has room.
    assign burst_ok  = elig[last] && (int'(burst_cnt) < BURST - 1);
    assign grant     = (state == ST_ARB) && !init && found;
    assign grant_idx = burst_ok ? last : pick_idx;
    assign pop       = grant ? onehot(grant_idx) : '0;
    assign idle      = (state == ST_IDLE) && !v1 && !valid_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_INIT;
            last      <= 2'd3;
            burst_cnt <= '0;
            v1        <= 1'b0;
            sel_q     <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            dest      <= '0;
        end else begin
            if (init) begin
                state <= ST_INIT;
            end else begin
                case (state)
                    ST_INIT: state <= ST_IDLE;
                    ST_IDLE: if (found)  state <= ST_ARB;
                    ST_ARB:  if (!found) state <= ST_IDLE;
                    default: state <= ST_INIT;
                endcase
            end

            if (state == ST_INIT) begin
                last      <= 2'd3;
                burst_cnt <= '0;
            end else if (grant) begin
                if (burst_ok) begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                end else begin
                    last      <= pick_idx;
                    burst_cnt <= '0;
                end
            end

            // FIFO read data lands one cycle after the pop; capture it with its class.
            v1 <= grant;
            if (grant) sel_q <= grant_idx;
            valid_out <= v1;
            if (v1) begin
                data_out <= fifo_data[int'(sel_q)*DATA_W +: DATA_W];
                dest     <= sel_q;
            end
        end
    end
endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Bench for vc_pop_arbiter: queue-backed FIFO environment, behavioural scheduler model,
// directed scenarios and randomized traffic on BURST=1 and BURST=2 instances.
module tb_vc_pop_arbiter;
    localparam int DW = 6;

    logic          clk;
    logic          reset;
    logic          init;
    logic [3:0]    pause;
    logic [3:0]    fifo_empty;
    logic [4*DW-1:0] fifo_data;
    logic          use_b2;

    logic [3:0]    pop1, pop2, pop_a;
    logic [DW-1:0] data1, data2, data_a;
    logic          vout1, vout2, vout_a;
    logic [1:0]    dest1, dest2, dest_a;
    logic          idle1, idle2, idle_a;
    logic          reset1, reset2;

    // Inactive instance is parked in reset.
    assign reset1 = reset | use_b2;
    assign reset2 = reset | ~use_b2;

    vc_pop_arbiter #(.DATA_W(DW), .BURST(1)) u_b1 (
        .clk(clk), .reset(reset1), .init(init), .pause(pause), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .pop(pop1), .data_out(data1), .valid_out(vout1),
        .dest(dest1), .idle(idle1));

    vc_pop_arbiter #(.DATA_W(DW), .BURST(2)) u_b2 (
        .clk(clk), .reset(reset2), .init(init), .pause(pause), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .pop(pop2), .data_out(data2), .valid_out(vout2),
        .dest(dest2), .idle(idle2));

    assign pop_a  = use_b2 ? pop2  : pop1;
    assign data_a = use_b2 ? data2 : data1;
    assign vout_a = use_b2 ? vout2 : vout1;
    assign dest_a = use_b2 ? dest2 : dest1;
    assign idle_a = use_b2 ? idle2 : idle1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO environment: contents and read-data registers.
    logic [DW-1:0] q [4][$];
    logic [DW-1:0] fd [4];
    assign fifo_data = {fd[3], fd[2], fd[1], fd[0]};

    // Reference model: phase 0=init, 1=idle, 2=arbitrating.
    int m_ph, m_last, m_cnt, m_burst;
    bit s1_v, o_v;
    int s1_c, o_c;
    logic [DW-1:0] s1_w, o_w;

    int errors = 0;
    int checks = 0;
    int grants[$];
    int dlog[$];
    int n_vout, l_dest, l_data;

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int rr(input logic [3:0] e, input int last);
        for (int k = 1; k <= 4; k++)
            if (e[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    task automatic upd_empty();
        for (int i = 0; i < 4; i++) fifo_empty[i] = (q[i].size() == 0);
    endtask

    task automatic push(input int c, input int n);
        for (int i = 0; i < n; i++) q[c].push_back(DW'($urandom));
        upd_empty();
    endtask

    task automatic clr();
        grants.delete();
        dlog.delete();
        n_vout = 0;
        l_dest = -1;
        l_data = -1;
    endtask

    task automatic m_reset(input int burst);
        m_ph = 0; m_last = 3; m_cnt = 0; m_burst = burst;
        s1_v = 0; o_v = 0; s1_c = 0; o_c = 0; s1_w = '0; o_w = '0;
    endtask

    // Entered and left at a falling edge. Reset is async, so outputs clear without a clock.
    task automatic do_reset(input bit b2);
        reset  = 1'b1;
        use_b2 = b2;
        #1;
        chk("rst_valid_out", int'(vout_a), 0);
        chk("rst_pop", int'(pop_a), 0);
        chk("rst_idle", int'(idle_a), 0);
        chk("rst_dest", int'(dest_a), 0);
        chk("rst_data_out", int'(data_a), 0);
        m_reset(b2 ? 2 : 1);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: check outputs against the model, then advance FIFOs and model.
    task automatic tick();
        logic [3:0] e, ep, ps;
        logic [DW-1:0] w;
        int g;
        bit cont;
        #1;
        e = ~fifo_empty & ~pause;
        ep = '0; g = -1; cont = 0; w = '0;
        if (!init && m_ph == 2 && e != 0) begin
            cont = e[m_last] && (m_cnt < m_burst - 1);
            g = cont ? m_last : rr(e, m_last);
            ep[g] = 1'b1;
            w = q[g][0];
        end
        chk("pop", int'(pop_a), int'(ep));
        chk("valid_out", int'(vout_a), int'(o_v));
        chk("idle", int'(idle_a), int'(m_ph == 1 && !s1_v && !o_v));
        if (o_v) begin
            chk("dest", int'(dest_a), o_c);
            chk("data_out", int'(data_a), int'(o_w));
        end
        if (vout_a) begin
            n_vout++;
            dlog.push_back(int'(dest_a));
            l_dest = int'(dest_a);
            l_data = int'(data_a);
        end
        ps = pop_a;
        for (int i = 0; i < 4; i++) if (ps[i]) grants.push_back(i);
        @(posedge clk);
        #1;
        o_v = s1_v; o_c = s1_c; o_w = s1_w;
        s1_v = (g >= 0); s1_c = g; s1_w = w;
        for (int i = 0; i < 4; i++)
            if (ps[i] && q[i].size() > 0) fd[i] = q[i].pop_front();
        if (m_ph == 0) begin
            m_last = 3; m_cnt = 0;
        end else if (g >= 0) begin
            if (cont) m_cnt++;
            else begin m_last = g; m_cnt = 0; end
        end
        if (init) m_ph = 0;
        else if (m_ph == 0) m_ph = 1;
        else if (m_ph == 1 && e != 0) m_ph = 2;
        else if (m_ph == 2 && e == 0) m_ph = 1;
        upd_empty();
        @(negedge clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (fifo_empty == 4'hF && m_ph == 1 && !s1_v && !o_v) break;
            tick();
        end
        chk("drain_idle", int'(idle_a), 1);
    endtask

    // seq packs 2-bit class indices, first entry in bits [1:0].
    task automatic chk_seq(input string tag, input bit use_dest, input logic [31:0] seq, input int n);
        int sz, v;
        sz = use_dest ? dlog.size() : grants.size();
        chk({tag, "_len"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            v = use_dest ? dlog[i] : grants[i];
            chk(tag, v, int'(seq[2*i +: 2]));
        end
    endtask

    task automatic rand_run(input int n);
        int c;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                c = $urandom_range(0, 3);
                if (q[c].size() < 8) push(c, $urandom_range(1, 3));
            end
            pause = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            init  = ($urandom_range(0, 40) == 0);
            if (i == n / 2) do_reset(use_b2);
            tick();
        end
        pause = 4'h0;
        init  = 1'b0;
        drain();
    endtask

    initial begin
        int v0;
        reset = 1'b1; init = 1'b0; pause = 4'h0; use_b2 = 1'b0;
        for (int i = 0; i < 4; i++) fd[i] = '0;
        upd_empty();
        m_reset(1);
        @(negedge clk);

        // Reset, init held 3 cycles with data waiting, then round-robin at BURST=1.
        do_reset(0);
        clr();
        init = 1'b1;
        for (int c = 0; c < 4; c++) push(c, 2);
        repeat (3) tick();
        chk("init_nopop", grants.size(), 0);
        init = 1'b0;
        tick();
        tick();
        chk("pre_arb_nopop", grants.size(), 0);
        tick();
        chk("first_pop_cnt", grants.size(), 1);
        chk("first_pop_cls", grants.size() > 0 ? grants[0] : -1, 0);
        drain();
        chk_seq("rr_b1_order", 0, 32'hE4E4, 8);
        chk_seq("rr_b1_dest", 1, 32'hE4E4, 8);

        // BURST=2 between classes 0 and 2.
        do_reset(1);
        clr();
        push(0, 4);
        push(2, 4);
        drain();
        chk_seq("burst2_order", 0, 32'hA0A0, 8);

        // Pause class 1 after its first grant, release after two cycles.
        do_reset(1);
        clr();
        push(1, 3);
        push(2, 2);
        for (int n = 0; n < 10 && grants.size() == 0; n++) tick();
        pause = 4'b0010;
        tick();
        tick();
        pause = 4'h0;
        drain();
        chk_seq("pause_order", 0, 32'h169, 5);

        // Single-entry FIFO on class 3.
        do_reset(1);
        clr();
        q[3].push_back(6'h2A);
        upd_empty();
        drain();
        chk("single_pops", grants.size(), 1);
        chk("single_vouts", n_vout, 1);
        chk("single_dest", l_dest, 3);
        chk("single_data", l_data, 'h2A);

        // Init arriving right after the second pop of a stream.
        do_reset(0);
        clr();
        for (int c = 0; c < 4; c++) push(c, 3);
        for (int n = 0; n < 10 && grants.size() < 2; n++) tick();
        v0 = n_vout;
        init = 1'b1;
        tick();
        chk("init_blocks_pop", grants.size(), 2);
        tick();
        chk("init_inflight", n_vout - v0, 2);
        for (int c = 0; c < 4; c++) q[c].delete();
        upd_empty();
        tick();
        init = 1'b0;
        drain();

        // Randomized traffic on both burst settings.
        do_reset(0);
        clr();
        rand_run(400);
        do_reset(1);
        clr();
        rand_run(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
